// File: rtl/mmio_csr_bank.sv
// CCI-P MMIO slave: DFH/AFU-ID/STATUS CSRs, NUM_REGS user registers and an
// in-order, TID-tracked forwarding window to a variable-latency backend.
module mmio_csr_bank #(
    parameter logic [127:0] AFU_ID    = 128'h0,
    parameter int           NUM_REGS  = 4,
    parameter logic [15:0]  USER_BASE = 16'h0020,
    parameter logic [15:0]  BE_BASE   = 16'h0300,
    parameter int           BE_WORDS  = 64,
    parameter int           RD_DEPTH  = 4,
    localparam int          BE_AW     = $clog2(BE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mmio_wr_valid,
    input  logic                     mmio_rd_valid,
    input  logic [15:0]              mmio_addr,
    input  logic [8:0]               mmio_tid,
    input  logic [63:0]              mmio_wr_data,
    output logic                     rsp_valid,
    output logic [8:0]               rsp_tid,
    output logic [63:0]              rsp_data,
    output logic [64*NUM_REGS-1:0]   user_regs,
    output logic                     be_req_valid,
    output logic                     be_req_write,
    output logic [BE_AW-1:0]         be_addr,
    output logic [63:0]              be_wdata,
    input  logic                     be_rd_valid,
    input  logic [63:0]              be_rd_data,
    output logic                     be_rd_ready
);
    localparam int          PTR_W     = $clog2(RD_DEPTH);
    localparam logic [16:0] USER_SPAN = 17'(2 * NUM_REGS);
    localparam logic [16:0] BE_SPAN   = 17'(2 * BE_WORDS);
    localparam logic [63:0] DFH       = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(inc);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [63:0]      regs [NUM_REGS];
    logic [8:0]       fifo_mem [RD_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic             hold_valid;
    logic [8:0]       hold_tid;
    logic [63:0]      hold_data;
    logic [31:0]      err_cnt;
    logic [7:0]       pending_cnt;

    logic [15:0] user_off, be_off;
    logic [4:0]  user_idx;
    logic        in_user, in_be;
    logic        fifo_full, be_rd_go, be_wr_go, loc_rd, full_err, be_acc, pop, stale;
    logic [63:0] loc_data;

    // Request decode (p0)
    assign user_off  = mmio_addr - USER_BASE;
    assign be_off    = mmio_addr - BE_BASE;
    assign user_idx  = user_off[5:1];
    assign in_user   = !mmio_addr[0] && (mmio_addr >= USER_BASE) && ({1'b0, user_off} < USER_SPAN);
    assign in_be     = !mmio_addr[0] && (mmio_addr >= BE_BASE) && ({1'b0, be_off} < BE_SPAN);

    assign fifo_full = (fifo_cnt == (PTR_W+1)'(RD_DEPTH));
    assign be_wr_go  = mmio_wr_valid && in_be;
    // A backend read colliding with a backend write, or hitting a full FIFO, is answered locally.
    assign be_rd_go  = mmio_rd_valid && in_be && !mmio_wr_valid && !fifo_full;
    assign full_err  = mmio_rd_valid && in_be && !mmio_wr_valid && fifo_full;
    assign loc_rd    = mmio_rd_valid && !be_rd_go;

    assign be_rd_ready = !hold_valid;
    assign be_acc      = be_rd_valid && be_rd_ready;
    assign pop         = be_acc && (fifo_cnt != '0);
    assign stale       = be_acc && (fifo_cnt == '0);
    assign pending_cnt = 8'(fifo_cnt) + 8'(hold_valid);

    always_comb begin
        loc_data = '0;
        case (mmio_addr)
            16'h0000: loc_data = DFH;
            16'h0002: loc_data = AFU_ID[63:0];
            16'h0004: loc_data = AFU_ID[127:64];
            16'h000A: loc_data = {err_cnt, 24'b0, pending_cnt};
            default:  loc_data = '0;
        endcase
        for (int i = 0; i < NUM_REGS; i++) begin
            if (in_user && (user_idx == 5'(i))) loc_data = regs[i];
        end
        if (in_be) loc_data = '1;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign user_regs[64*g +: 64] = regs[g];
    end

    // Registered outputs and state (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_tid      <= '0;
            rsp_data     <= '0;
            be_req_valid <= 1'b0;
            be_req_write <= 1'b0;
            be_addr      <= '0;
            be_wdata     <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_cnt     <= '0;
            hold_valid   <= 1'b0;
            hold_tid     <= '0;
            hold_data    <= '0;
            err_cnt      <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (mmio_wr_valid && in_user && (user_idx == 5'(i))) regs[i] <= mmio_wr_data;
            end

            be_req_valid <= be_rd_go || be_wr_go;
            be_req_write <= be_wr_go;
            be_addr      <= be_off[BE_AW:1];
            be_wdata     <= mmio_wr_data;

            if (be_rd_go) begin
                fifo_mem[wr_ptr] <= mmio_tid;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + (PTR_W+1)'(be_rd_go) - (PTR_W+1)'(pop);
            err_cnt  <= sat_add(err_cnt, {1'b0, full_err} + {1'b0, stale});

            // Local responses win; a backend return that loses is parked in the hold slot.
            if (loc_rd) begin
                rsp_valid <= 1'b1;
                rsp_tid   <= mmio_tid;
                rsp_data  <= loc_data;
                if (pop) begin
                    hold_valid <= 1'b1;
                    hold_tid   <= fifo_mem[rd_ptr];
                    hold_data  <= be_rd_data;
                end
            end else if (hold_valid) begin
                rsp_valid  <= 1'b1;
                rsp_tid    <= hold_tid;
                rsp_data   <= hold_data;
                hold_valid <= 1'b0;
            end else if (pop) begin
                rsp_valid <= 1'b1;
                rsp_tid   <= fifo_mem[rd_ptr];
                rsp_data  <= be_rd_data;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mmio_csr_bank.sv
// Bench for mmio_csr_bank: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mmio_csr_bank;
    localparam logic [127:0] AFU_ID    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam int           NUM_REGS  = 4;
    localparam int           USER_BASE = 'h20;
    localparam int           BE_BASE   = 'h300;
    localparam int           BE_WORDS  = 64;
    localparam int           RD_DEPTH  = 4;
    localparam int           BE_AW     = $clog2(BE_WORDS);

    logic                   clk, rst;
    logic                   mmio_wr_valid, mmio_rd_valid;
    logic [15:0]            mmio_addr;
    logic [8:0]             mmio_tid;
    logic [63:0]            mmio_wr_data;
    logic                   rsp_valid;
    logic [8:0]             rsp_tid;
    logic [63:0]            rsp_data;
    logic [64*NUM_REGS-1:0] user_regs;
    logic                   be_req_valid, be_req_write;
    logic [BE_AW-1:0]       be_addr;
    logic [63:0]            be_wdata;
    logic                   be_rd_valid;
    logic [63:0]            be_rd_data;
    logic                   be_rd_ready;

    mmio_csr_bank #(
        .AFU_ID(AFU_ID), .NUM_REGS(NUM_REGS), .USER_BASE(16'(USER_BASE)),
        .BE_BASE(16'(BE_BASE)), .BE_WORDS(BE_WORDS), .RD_DEPTH(RD_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .user_regs(user_regs),
        .be_req_valid(be_req_valid), .be_req_write(be_req_write),
        .be_addr(be_addr), .be_wdata(be_wdata),
        .be_rd_valid(be_rd_valid), .be_rd_data(be_rd_data), .be_rd_ready(be_rd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_regs [NUM_REGS];
    logic [8:0]  m_pend [$];
    logic [72:0] m_ret  [$];
    longint      m_err;
    bit          armed = 0;
    logic        e_rsp_v, e_req_v, e_req_w, e_ready;
    logic [8:0]  e_rsp_tid;
    logic [63:0] e_rsp_data, e_wdata;
    int          e_req_addr;

    function automatic bit is_be(int a);
        return (a % 2 == 0) && (a >= BE_BASE) && (a < BE_BASE + 2*BE_WORDS);
    endfunction
    function automatic bit is_user(int a);
        return (a % 2 == 0) && (a >= USER_BASE) && (a < USER_BASE + 2*NUM_REGS);
    endfunction
    function automatic logic [63:0] local_val(int a, logic [7:0] pcnt);
        if (is_be(a)) return '1;
        if (is_user(a)) return m_regs[(a - USER_BASE) / 2];
        case (a)
            0:  return 64'h1000_0100_0000_0000;
            2:  return AFU_ID[63:0];
            4:  return AFU_ID[127:64];
            10: return {m_err[31:0], 24'b0, pcnt};
            default: return '0;
        endcase
    endfunction
    task automatic bump_err();
        if (m_err < 64'hFFFF_FFFF) m_err++;
    endtask

    always @(posedge clk) begin : model
        int a, pre_pend;
        logic [7:0] pcnt;
        logic [63:0] lval;
        bit lrd;
        if (rst) begin
            m_pend.delete();
            m_ret.delete();
            m_err = 0;
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            e_rsp_v = 0; e_req_v = 0; e_req_w = 0; e_ready = 1;
            e_rsp_tid = '0; e_rsp_data = '0; e_wdata = '0; e_req_addr = 0;
            armed = 1;
        end else begin
            a        = int'(mmio_addr);
            pre_pend = m_pend.size();
            pcnt     = 8'(m_pend.size() + m_ret.size());
            lrd = 0; lval = '0;
            e_rsp_v = 0; e_req_v = 0; e_req_w = 0;
            if (be_rd_valid && e_ready) begin
                if (m_pend.size() == 0) bump_err();
                else m_ret.push_back({m_pend.pop_front(), be_rd_data});
            end
            if (mmio_rd_valid) begin
                if (is_be(a) && !mmio_wr_valid && pre_pend < RD_DEPTH) begin
                    m_pend.push_back(mmio_tid);
                    e_req_v = 1; e_req_addr = (a - BE_BASE) / 2;
                end else begin
                    lrd = 1;
                    lval = local_val(a, pcnt);
                    if (is_be(a) && !mmio_wr_valid) bump_err();
                end
            end
            if (mmio_wr_valid) begin
                if (is_user(a)) m_regs[(a - USER_BASE) / 2] = mmio_wr_data;
                if (is_be(a)) begin
                    e_req_v = 1; e_req_w = 1; e_req_addr = (a - BE_BASE) / 2; e_wdata = mmio_wr_data;
                end
            end
            if (lrd) begin
                e_rsp_v = 1; e_rsp_tid = mmio_tid; e_rsp_data = lval;
            end else if (m_ret.size() > 0) begin
                e_rsp_v = 1; {e_rsp_tid, e_rsp_data} = m_ret.pop_front();
            end
            e_ready = (m_ret.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_v));
            if (e_rsp_v) begin
                chk("rsp_tid", 64'(rsp_tid), 64'(e_rsp_tid));
                chk("rsp_data", rsp_data, e_rsp_data);
            end
            chk("be_req_valid", 64'(be_req_valid), 64'(e_req_v));
            if (e_req_v) begin
                chk("be_req_write", 64'(be_req_write), 64'(e_req_w));
                chk("be_addr", 64'(be_addr), 64'(e_req_addr));
                if (e_req_w) chk("be_wdata", be_wdata, e_wdata);
            end
            chk("be_rd_ready", 64'(be_rd_ready), 64'(e_ready));
            for (int i = 0; i < NUM_REGS; i++) chk("user_regs", user_regs[64*i +: 64], m_regs[i]);
        end
    end

    // ---------------- backend stub ----------------
    logic [63:0] be_q [$];
    bit          be_stall = 1;
    bit          force_en = 0;
    logic [63:0] force_val = '0;
    bit          offered_ok = 0;

    initial begin
        be_rd_valid = 0;
        be_rd_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (offered_ok) void'(be_q.pop_front());
            if (be_req_valid && !be_req_write) be_q.push_back(force_en ? force_val : {$urandom, $urandom});
            if (!be_stall && be_q.size() > 0 && (force_en || $urandom_range(0, 3) != 0)) begin
                be_rd_valid = 1; be_rd_data = be_q[0];
            end else begin
                be_rd_valid = 0;
            end
            offered_ok = be_rd_valid && be_rd_ready;
        end
    end

    // ---------------- drivers ----------------
    task automatic idle();
        @(negedge clk);
        mmio_rd_valid = 0; mmio_wr_valid = 0;
    endtask
    task automatic issue_rd(input logic [15:0] a, input logic [8:0] t);
        @(negedge clk);
        mmio_wr_valid = 0; mmio_rd_valid = 1; mmio_addr = a; mmio_tid = t;
    endtask
    task automatic do_wr(input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        mmio_rd_valid = 0; mmio_wr_valid = 1; mmio_addr = a; mmio_wr_data = d;
        @(negedge clk);
        mmio_wr_valid = 0;
    endtask
    task automatic wait_rsp(input string name, input logic [8:0] t, input logic [63:0] exp);
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (rsp_valid && rsp_tid == t) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no response for tid %0d within 60 cycles", name, t);
        end else chk(name, rsp_data, exp);
    endtask
    task automatic rd_expect(input string name, input logic [15:0] a, input logic [8:0] t, input logic [63:0] exp);
        issue_rd(a, t);
        idle();
        wait_rsp(name, t, exp);
    endtask
    task automatic drain();
        be_stall = 0;
        for (int i = 0; i < 500; i++) begin
            if (be_q.size() == 0 && m_pend.size() == 0 && m_ret.size() == 0 && !be_rd_valid) break;
            idle();
        end
        chk("drain_empty", 64'(be_q.size() + m_pend.size() + m_ret.size()), 64'd0);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1; mmio_rd_valid = 0; mmio_wr_valid = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] tids [$];
        int quiet;
        rst = 1; mmio_wr_valid = 0; mmio_rd_valid = 0;
        mmio_addr = '0; mmio_tid = '0; mmio_wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_tid", 64'(rsp_tid), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_be_req", 64'({be_req_valid, be_req_write, be_addr}), 64'd0);
        chk("reset_be_rd_ready", 64'(be_rd_ready), 64'd1);
        for (int i = 0; i < NUM_REGS; i++) chk("reset_user_regs", user_regs[64*i +: 64], 64'd0);

        rd_expect("dfh", 16'h0000, 9'd5, 64'h1000_0100_0000_0000);
        rd_expect("id_l", 16'h0002, 9'd6, 64'hFEDC_BA98_7654_3210);
        rd_expect("id_h", 16'h0004, 9'd7, 64'h0123_4567_89AB_CDEF);
        rd_expect("rsvd6", 16'h0006, 9'd8, 64'd0);
        rd_expect("odd", 16'h0001, 9'd9, 64'd0);

        do_wr(16'h0022, 64'hDEAD_BEEF_0123_4567);
        chk("user1_visible", user_regs[127:64], 64'hDEAD_BEEF_0123_4567);
        rd_expect("user1_read", 16'h0022, 9'd10, 64'hDEAD_BEEF_0123_4567);
        do_wr(16'h0021, 64'h5555_5555_5555_5555);
        chk("odd_wr_r0", user_regs[63:0], 64'd0);
        chk("odd_wr_r1", user_regs[127:64], 64'hDEAD_BEEF_0123_4567);
        chk("odd_wr_r2", user_regs[191:128], 64'd0);
        do_wr(16'h000A, 64'h1234);
        rd_expect("status_ro", 16'h000A, 9'd11, 64'd0);

        // write and read of the same register in one cycle
        @(negedge clk);
        mmio_wr_valid = 1; mmio_rd_valid = 1; mmio_addr = 16'h0022; mmio_tid = 9'd12;
        mmio_wr_data = 64'h1111_2222_3333_4444;
        idle();
        chk("wr_rd_tid", 64'(rsp_tid), 64'd12);
        chk("wr_rd_old", rsp_data, 64'hDEAD_BEEF_0123_4567);
        chk("wr_rd_new", user_regs[127:64], 64'h1111_2222_3333_4444);

        // backend read with a 7-cycle return
        force_en = 1; force_val = 64'hAA; be_stall = 1;
        issue_rd(16'h0304, 9'd9);
        idle();
        chk("be_req", 64'({be_req_valid, be_req_write}), 64'b10);
        chk("be_addr_2", 64'(be_addr), 64'd2);
        repeat (6) idle();
        be_stall = 0;
        wait_rsp("be_return", 9'd9, 64'hAA);

        // FIFO overflow
        drain();
        do_reset();
        be_stall = 1; force_val = 64'hBEEF;
        for (int i = 0; i < 5; i++) issue_rd(16'h0300 + 16'(2*i), 9'(20 + i));
        idle();
        chk("ovf_tid", 64'(rsp_valid ? rsp_tid : 9'h1FF), 64'd24);
        chk("ovf_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_expect("status_ovf", 16'h000A, 9'd30, 64'h0000_0001_0000_0004);
        be_stall = 0;
        for (int i = 0; i < 100 && tids.size() < 4; i++) begin
            idle();
            if (rsp_valid) tids.push_back(rsp_tid);
        end
        chk("ovf_count", 64'(tids.size()), 64'd4);
        for (int i = 0; i < 4 && i < tids.size(); i++) chk("ovf_order", 64'(tids[i]), 64'(20 + i));

        // backend return colliding with a local response
        drain();
        be_stall = 1;
        issue_rd(16'h0310, 9'd11);
        repeat (3) idle();
        @(negedge clk);
        be_stall = 0; mmio_rd_valid = 1; mmio_addr = 16'h0000; mmio_tid = 9'd12;
        idle();
        chk("coll_first", 64'({rsp_valid, rsp_tid}), 64'({1'b1, 9'd12}));
        chk("coll_ready0", 64'(be_rd_ready), 64'd0);
        idle();
        chk("coll_second", 64'({rsp_valid, rsp_tid}), 64'({1'b1, 9'd11}));
        chk("coll_data", rsp_data, 64'hBEEF);
        chk("coll_ready1", 64'(be_rd_ready), 64'd1);

        // reset with reads in flight
        drain();
        do_reset();
        do_wr(16'h0020, 64'h1234);
        be_stall = 1;
        for (int i = 0; i < 3; i++) issue_rd(16'h0300, 9'(40 + i));
        idle();
        do_reset();
        be_stall = 0;
        quiet = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (rsp_valid) quiet++;
        end
        chk("rst_no_rsp", 64'(quiet), 64'd0);
        for (int i = 0; i < NUM_REGS; i++) chk("rst_user_regs", user_regs[64*i +: 64], 64'd0);
        rd_expect("status_stale", 16'h000A, 9'd50, 64'h0000_0003_0000_0000);

        // randomized traffic
        force_en = 0;
        for (int c = 0; c < 3000; c++) begin
            int r, k;
            logic [15:0] a;
            @(negedge clk);
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 11);
            case (k)
                0: a = 16'(2 * $urandom_range(0, 5));
                1: a = 16'h000A;
                2, 3: a = 16'(USER_BASE + 2 * $urandom_range(0, NUM_REGS - 1));
                4: a = 16'(USER_BASE + 2 * NUM_REGS);
                5, 6, 7: a = 16'(BE_BASE + 2 * $urandom_range(0, BE_WORDS - 1));
                8: a = 16'(BE_BASE + 2 * BE_WORDS);
                9: a = 16'(BE_BASE + 2 * $urandom_range(0, BE_WORDS - 1) + 1);
                default: a = 16'($urandom);
            endcase
            mmio_addr     = a;
            mmio_tid      = 9'($urandom);
            mmio_wr_data  = {$urandom, $urandom};
            mmio_wr_valid = (r < 3) || (r == 9);
            mmio_rd_valid = (r >= 3);
            be_stall      = ($urandom_range(0, 9) < 3);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
